// File: rtl/io_map_pkg.sv
// Shared I/O map: bus width, peripheral base addresses, UART status bit layout and TX FSM states.
// IO_UART_TX_PARITY_EN adds the TX_PARITY state to tx_state_t.
package io_map_pkg;

  localparam int CPU_WIDTH = 16;

  localparam logic [CPU_WIDTH-1:0] UART_TX_BASE = 16'h4000;
  localparam logic [CPU_WIDTH-1:0] UART_RX_BASE = 16'h4010;
  localparam logic [CPU_WIDTH-1:0] TIMER_BASE   = 16'h4020;
  localparam logic [CPU_WIDTH-1:0] GPIO_BASE    = 16'h4030;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 5;
  localparam int ST_PARITY    = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef IO_UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU I/O port bundle: address/store strobe/store data from the CPU, combinational read data back.
interface io_uart_tx_if;
  import io_map_pkg::*;

  logic [CPU_WIDTH-1:0] io_addr;
  logic                 io_write;
  logic [CPU_WIDTH-1:0] io_wr_data;
  logic [CPU_WIDTH-1:0] io_rd_data;

  modport master (
    output io_addr,
    output io_write,
    output io_wr_data,
    input  io_rd_data
  );

  modport slave (
    input  io_addr,
    input  io_write,
    input  io_wr_data,
    output io_rd_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: registered pointers/count, head visible combinationally on pop_data.
// Push while full is ignored (full is the pre-edge value); pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS decode, byte FIFO, 8N1 serialiser; first start bit one clock after the store.
// IO_UART_TX_PARITY_EN inserts an even-parity bit before stop and sets STATUS bit9; stores to a full FIFO drop and set overflow.
module io_uart_tx
  import io_map_pkg::*;
#(
  parameter int                   CLKS_PER_BIT = 217,
  parameter int                   FIFO_DEPTH   = 8,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR    = 16'h4000
) (
  input  logic         clock,
  input  logic         reset,
  io_uart_tx_if.slave  bus,
  output logic         uart_tx,
  output logic         tx_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]        BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CPU_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + CPU_WIDTH'(1);

  logic       data_sel;
  logic       status_sel;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] head;
  logic [AW:0] count;
  logic       ovf_q;
  logic       baud_end;
  logic [CPU_WIDTH-1:0] status;
  logic       unused_wr_hi;

  tx_state_t  state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       tx_q, tx_d;
  logic       act_q, act_d;
`ifdef IO_UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign data_sel     = (bus.io_addr == BASE_ADDR);
  assign status_sel   = (bus.io_addr == STATUS_ADDR);
  assign push         = bus.io_write && data_sel;
  assign unused_wr_hi = ^bus.io_wr_data[CPU_WIDTH-1:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.io_wr_data[7:0]),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (push && full) begin
      ovf_q <= 1'b1;
    end else if (bus.io_write && status_sel && bus.io_wr_data[ST_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    status                               = '0;
    status[ST_BUSY]                      = (state_q != TX_IDLE);
    status[ST_FULL]                      = full;
    status[ST_EMPTY]                     = empty;
    status[ST_OVF]                       = ovf_q;
    status[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(count);
`ifdef IO_UART_TX_PARITY_EN
    status[ST_PARITY]                    = 1'b1;
`endif
    bus.io_rd_data = status_sel ? status : '0;
  end

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    act_d   = act_q;
    pop     = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          baud_d  = '0;
          tx_d    = 1'b0;
          act_d   = 1'b1;
          state_d = TX_START;
`ifdef IO_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      TX_START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shreg_q[0];
          idx_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = TX_PARITY;
`else
            tx_d    = 1'b1;
            state_d = TX_STOP;
`endif
          end else begin
            // shreg[0] always holds the bit currently on the line
            idx_d   = idx_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      TX_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = TX_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      TX_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          act_d   = 1'b0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        act_d   = 1'b0;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign uart_tx   = tx_q;
  assign tx_active = act_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx with CLKS_PER_BIT=4: directed stores/reads, frame scoreboard checked by a line monitor.
module tb_io_uart_tx;

  localparam int CPB = 4;
`ifdef IO_UART_TX_PARITY_EN
  localparam int          NB      = 11;
  localparam logic [15:0] EXP_PAR = 16'h0200;
`else
  localparam int          NB      = 10;
  localparam logic [15:0] EXP_PAR = 16'h0000;
`endif
  localparam logic [15:0] DATA_A = 16'h4000;
  localparam logic [15:0] STAT_A = 16'h4001;

  logic clock;
  logic reset;
  logic uart_tx;
  logic tx_active;

  int   vectors;
  int   miscompares;
  bit   abort_pending;
  logic [7:0] exp_q [$];

  io_uart_tx_if bus ();

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (16'h4000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .uart_tx   (uart_tx),
    .tx_active (tx_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef IO_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic drive(input logic [15:0] a, input logic w, input logic [15:0] d);
    @(negedge clock);
    bus.io_addr    = a;
    bus.io_write   = w;
    bus.io_wr_data = d;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    drive(STAT_A, 1'b0, 16'h0000);
    #1;
    while (!(tx_active == 1'b0 && bus.io_rd_data[2] == 1'b1 && bus.io_rd_data[0] == 1'b0) && t < 3000) begin
      @(negedge clock);
      #1;
      t++;
    end
    check("wait_idle_timeout", {31'd0, t >= 3000}, 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Monitor: one scoreboard pop per frame, bits sampled mid-bit.
  initial begin : monitor
    logic       prev;
    int         n;
    logic [10:0] bits;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_active && !prev) begin
        n    = 0;
        bits = '0;
        while (tx_active && n < 4 * NB * CPB) begin
          if ((n % CPB) == (CPB / 2) && (n / CPB) < NB) bits[n / CPB] = uart_tx;
          n++;
          @(negedge clock);
        end
        if (abort_pending) begin
          abort_pending = 1'b0;
          if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", {21'd0, bits}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", {21'd0, bits}, {21'd0, frame_of(e)});
          check("frame_len", n, NB * CPB);
        end
      end
      prev = tx_active;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] burst [10];
    int   t;
    logic any_active;

    vectors        = 0;
    miscompares    = 0;
    abort_pending  = 1'b0;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99, 8'hC3};
    bus.io_addr    = STAT_A;
    bus.io_write   = 1'b0;
    bus.io_wr_data = 16'h0000;
    reset          = 1'b1;

    repeat (3) @(negedge clock);
    #1;
    check("rst_uart_tx",   {31'd0, uart_tx},   32'd1);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    check("rst_status",    {16'd0, bus.io_rd_data}, {16'd0, 16'h0004 | EXP_PAR});
    reset = 1'b0;

    drive(16'h4002, 1'b0, 16'h0000); #1;
    check("unmapped_read", {16'd0, bus.io_rd_data}, 32'd0);
    drive(DATA_A, 1'b0, 16'h0000); #1;
    check("data_read_zero", {16'd0, bus.io_rd_data}, 32'd0);

    // Single store; upper data bits must be ignored.
    exp_q.push_back(8'h55);
    drive(DATA_A, 1'b1, 16'hAB55);
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_after_write", {16'd0, bus.io_rd_data}, {16'd0, 16'h0010 | EXP_PAR});
    check("line_before_pop", {31'd0, uart_tx}, 32'd1);
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_after_pop", {16'd0, bus.io_rd_data}, {16'd0, 16'h0005 | EXP_PAR});
    check("line_start_bit", {31'd0, uart_tx}, 32'd0);
    check("active_at_start", {31'd0, tx_active}, 32'd1);
    wait_idle();

    // Ten back-to-back stores: b0 popped, b1..b8 held, b9 dropped.
    for (int i = 0; i < 10; i++) begin
      drive(DATA_A, 1'b1, {8'h00, burst[i]});
      if (i < 9) exp_q.push_back(burst[i]);
    end
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_full_ovf", {16'd0, bus.io_rd_data}, {16'd0, 16'h008B | EXP_PAR});
    drive(STAT_A, 1'b1, 16'hFFF7);
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_ovf_kept", {16'd0, bus.io_rd_data}, {16'd0, 16'h008B | EXP_PAR});
    drive(STAT_A, 1'b1, 16'h0008);
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_ovf_clr", {16'd0, bus.io_rd_data}, {16'd0, 16'h0083 | EXP_PAR});

    // Store while full on the edge the FSM pops: dropped, count 8 -> 7.
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (tx_active && t < 1000);
    check("pop_edge_timeout", {31'd0, t >= 1000}, 32'd0);
    bus.io_addr    = DATA_A;
    bus.io_write   = 1'b1;
    bus.io_wr_data = 16'h00EE;
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_push_on_pop", {16'd0, bus.io_rd_data}, {16'd0, 16'h0079 | EXP_PAR});
    wait_idle();
    check("st_ovf_sticky", {16'd0, bus.io_rd_data}, {16'd0, 16'h000C | EXP_PAR});
    drive(STAT_A, 1'b1, 16'h0008);
    drive(STAT_A, 1'b0, 16'h0000); #1;
    check("st_idle_clean", {16'd0, bus.io_rd_data}, {16'd0, 16'h0004 | EXP_PAR});

    // Reset during data bit 3 of 8'hA5 (bit3 = 0 on the line).
    exp_q.push_back(8'hA5);
    drive(DATA_A, 1'b1, 16'h00A5);
    drive(STAT_A, 1'b0, 16'h0000);
    repeat (17) @(negedge clock);
    #1;
    check("pre_reset_line", {31'd0, uart_tx}, 32'd0);
    #1;
    abort_pending = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_async_line",   {31'd0, uart_tx},   32'd1);
    check("rst_async_active", {31'd0, tx_active}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("st_after_abort", {16'd0, bus.io_rd_data}, {16'd0, 16'h0004 | EXP_PAR});
    any_active = 1'b0;
    repeat (60) begin
      @(negedge clock);
      any_active = any_active | tx_active | ~uart_tx;
    end
    check("no_frame_resume", {31'd0, any_active}, 32'd0);

`ifdef IO_UART_TX_PARITY_EN
    exp_q.push_back(8'h07);
    drive(DATA_A, 1'b1, 16'h0007);
    wait_idle();
`endif

    repeat (5) @(negedge clock);
    check("frames_pending", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
